debug_monitor: RTL and testbench

DEBUG_MONITOR -- requirements
Module: debug_monitor

---
 rtl/debug_pkg.sv | 15 +
 rtl/hex_seg7.sv | 11 +
 rtl/debug_monitor.sv | 143 ++++++++++++++
 tb/tb_debug_monitor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared display constants for the debug monitor: segment glyphs and
// digit/segment drive polarity.
package debug_pkg;

  localparam logic       ANODE_ON  = 1'b0;
  localparam logic       ANODE_OFF = 1'b1;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_seg7
  import debug_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPH_TBL[hex_i];

endmodule

// File: rtl/debug_monitor.sv
// On-board debug monitor: channel capture with freeze, scanned hex display,
// and a debounced single-step clock enable.
module debug_monitor
  import debug_pkg::*;
#(
  parameter int NUM_CH       = 16,
  parameter int DATA_W       = 32,
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DATA_W-1:0]   probe_bus,
  input  logic [$clog2(NUM_CH)-1:0]  ch_sel,
  input  logic [2:0]                 page_sel,
  input  logic                       freeze,
  input  logic                       run_mode,
  input  logic                       step_btn,
  output logic                       step_en,
  output logic [15:0]                leds,
  output logic [DIGITS-1:0]          anode,
  output logic [6:0]                 seg
);

  localparam int WIN_W     = 4 * DIGITS;
  localparam int NUM_PAGES = DATA_W / WIN_W;
  localparam int REF_W     = $clog2(REFRESH_DIV);
  localparam int DIG_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DB_W      = $clog2(DEBOUNCE_CYC);

  logic [DATA_W-1:0] cap_q, cap_d;

  always_comb begin
    cap_d = cap_q;
    if (!freeze) begin
      if (int'(ch_sel) < NUM_CH) cap_d = probe_bus[int'(ch_sel)*DATA_W +: DATA_W];
      else                       cap_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cap_q <= '0;
    else     cap_q <= cap_d;
  end

  if (DATA_W >= 16) begin : g_leds_full
    assign leds = cap_q[15:0];
  end else begin : g_leds_narrow
    assign leds = {{(16-DATA_W){1'b0}}, cap_q};
  end

  logic [2:0]       page_eff;
  logic [WIN_W-1:0] window;
  logic [3:0]       nibble;
  logic [6:0]       glyph;

  assign page_eff = (int'(page_sel) < NUM_PAGES) ? page_sel : 3'd0;
  assign window   = cap_q[int'(page_eff)*WIN_W +: WIN_W];

  logic [REF_W-1:0]  ref_q;
  logic [DIG_W-1:0]  digit_q;
  logic              upd_q;
  logic              wrap;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [6:0]        seg_q;

  assign wrap   = (ref_q == REF_W'(REFRESH_DIV-1));
  assign nibble = window[int'(digit_q)*4 +: 4];

  hex_seg7 u_hex_seg7 (
    .hex_i (nibble),
    .seg_o (glyph)
  );

  always_comb begin
    anode_d = '1;
    for (int i = 0; i < DIGITS; i++)
      anode_d[i] = (DIG_W'(i) == digit_q) ? ANODE_ON : ANODE_OFF;
  end

  // Display registers load one cycle after the digit index moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q   <= '0;
      digit_q <= '0;
      upd_q   <= 1'b0;
      anode_q <= {DIGITS{ANODE_OFF}};
      seg_q   <= SEG_BLANK;
    end else begin
      ref_q <= wrap ? '0 : ref_q + 1'b1;
      upd_q <= wrap;
      if (wrap)
        digit_q <= (digit_q == DIG_W'(DIGITS-1)) ? '0 : digit_q + 1'b1;
      if (upd_q) begin
        anode_q <= anode_d;
        seg_q   <= glyph;
      end
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;

  logic            sync1_q, sync2_q;
  logic            acc_q, arm_q, pulse_q;
  logic [DB_W-1:0] db_cnt_q;
  logic [1:0]      settle_q;
  logic            db_hit;

  assign db_hit = (sync2_q != acc_q) && (db_cnt_q == DB_W'(DEBOUNCE_CYC-1));

  // arm_q blocks a step for a button already held when reset released;
  // settle_q waits out the synchroniser's stale post-reset zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      acc_q    <= 1'b0;
      db_cnt_q <= '0;
      pulse_q  <= 1'b0;
      arm_q    <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      sync1_q <= step_btn;
      sync2_q <= sync1_q;
      if (sync2_q == acc_q) begin
        db_cnt_q <= '0;
      end else if (db_hit) begin
        db_cnt_q <= '0;
        acc_q    <= sync2_q;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
      pulse_q <= db_hit && sync2_q && arm_q;
      if (settle_q != 2'd2)           settle_q <= settle_q + 2'd1;
      else if (!acc_q && !sync2_q)    arm_q    <= 1'b1;
    end
  end

  assign step_en = rst ? 1'b0 : (run_mode | pulse_q);

endmodule

// File: tb/tb_debug_monitor.sv
// Scoreboard bench for debug_monitor: a cycle-level reference model queues
// expected outputs at each rising edge, a monitor compares on the falling edge.
module tb_debug_monitor;

  localparam int NCH  = 12;
  localparam int DW   = 32;
  localparam int ND   = 4;
  localparam int RDIV = 4;
  localparam int DBC  = 8;

  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH*DW-1:0] probe_bus;
  logic [3:0]      ch_sel;
  logic [2:0]      page_sel;
  logic            freeze, run_mode, step_btn;
  logic            step_en;
  logic [15:0]     leds;
  logic [ND-1:0]   anode;
  logic [6:0]      seg;
  logic [31:0]     chan [NCH];

  always #5 clk = ~clk;

  always_comb begin
    probe_bus = '0;
    for (int k = 0; k < NCH; k++) probe_bus[k*DW +: DW] = chan[k];
  end

  debug_monitor #(
    .NUM_CH(NCH), .DATA_W(DW), .DIGITS(ND), .REFRESH_DIV(RDIV), .DEBOUNCE_CYC(DBC)
  ) dut (
    .clk(clk), .rst(rst), .probe_bus(probe_bus), .ch_sel(ch_sel),
    .page_sel(page_sel), .freeze(freeze), .run_mode(run_mode),
    .step_btn(step_btn), .step_en(step_en), .leds(leds), .anode(anode), .seg(seg)
  );

  typedef struct packed {
    logic [15:0] leds;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        pulse;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   last_pulse_cyc = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: capture, scan slot timing and debounce expressed over
  // edges counted since reset and the history of sampled button levels.
  initial begin : model
    logic [31:0] m_cap;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    int          m_e, idx, pg;
    bit          m_acc, m_arm, pul, all_diff, sync_now, arm_before;
    bit          bq[$];
    m_cap = '0; m_an = 4'hF; m_seg = 7'h7F; m_e = 0; m_acc = 0; m_arm = 0;
    forever begin
      @(posedge clk);
      pul = 0;
      if (rst) begin
        m_cap = '0; m_an = 4'hF; m_seg = 7'h7F; m_e = 0;
        m_acc = 0; m_arm = 0; bq.delete();
      end else begin
        m_e++;
        bq.push_back(step_btn);
        if (m_e > RDIV && (m_e - 1) % RDIV == 0) begin
          idx   = ((m_e - 1) / RDIV) % ND;
          pg    = (page_sel < 3'd2) ? int'(page_sel) : 0;
          m_an  = ~(4'b0001 << idx);
          m_seg = GLY[m_cap[pg*16 + idx*4 +: 4]];
        end
        // debouncer sees the button level from two edges ago
        sync_now = (m_e >= 3) ? bq[m_e-3] : 1'b0;
        all_diff = (m_e >= DBC + 2);
        if (all_diff)
          for (int j = m_e - DBC - 2; j <= m_e - 3; j++)
            if (bq[j] == m_acc) all_diff = 0;
        arm_before = m_arm;
        if (m_e >= 3 && !m_acc && !sync_now) m_arm = 1;
        if (all_diff) begin
          pul   = !m_acc && arm_before;
          m_acc = !m_acc;
        end
        if (!freeze) m_cap = (ch_sel < 4'(NCH)) ? chan[ch_sel] : 32'hFFFF_FFFF;
      end
      expq.push_back('{m_cap[15:0], m_an, m_seg, pul});
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("leds", 32'(leds), 32'(e.leds));
        chk("anode", 32'(anode), 32'(e.anode));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("step_en", 32'(step_en), rst ? 32'd0 : (run_mode ? 32'd1 : 32'(e.pulse)));
      end
      if (!rst && !run_mode && step_en) begin
        pulse_cnt++;
        last_pulse_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    int p0, c0, btn_hold;
    rst = 1'b1; ch_sel = '0; page_sel = '0; freeze = 1'b0;
    run_mode = 1'b1; step_btn = 1'b0;
    for (int k = 0; k < NCH; k++) chan[k] = $urandom;
    tick(3);
    @(negedge clk);
    chk("reset_leds", 32'(leds), 32'd0);
    chk("reset_anode", 32'(anode), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_step_en", 32'(step_en), 32'd0);
    tick(1);

    rst = 1'b0;
    tick(10);
    @(negedge clk);
    chk("free_run_step_en", 32'(step_en), 32'd1);
    tick(1);
    run_mode = 1'b0;
    @(negedge clk);
    chk("run_off_same_cycle", 32'(step_en), 32'd0);
    tick(1);

    chan[5] = 32'hDEAD_BEEF; ch_sel = 4'd5; freeze = 1'b0;
    tick(1);
    freeze = 1'b1; chan[5] = 32'h0;
    tick(100);
    @(negedge clk);
    chk("freeze_hold", 32'(leds), 32'hBEEF);
    tick(1);

    freeze = 1'b0; chan[5] = 32'h1234_5678;
    tick(1);
    freeze = 1'b1; page_sel = 3'd1;
    tick(40);
    page_sel = 3'd6;
    tick(20);

    freeze = 1'b0; ch_sel = 4'd13;
    tick(1);
    @(negedge clk);
    chk("ch_out_of_range", 32'(leds), 32'hFFFF);
    tick(1);

    step_btn = 1'b0;
    tick(20);
    p0 = pulse_cnt;
    step_btn = 1'b1; tick(5); step_btn = 1'b0; tick(20);
    chk("glitch_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    p0 = pulse_cnt;
    c0 = cyc;
    step_btn = 1'b1; tick(20); step_btn = 1'b0; tick(20);
    chk("press_one_pulse", 32'(pulse_cnt - p0), 32'd1);
    chk("press_latency", 32'(last_pulse_cyc - c0), 32'd10);

    p0 = pulse_cnt;
    step_btn = 1'b1; tick(6);
    rst = 1'b1; tick(2); rst = 1'b0;
    tick(30);
    chk("reset_mid_debounce", 32'(pulse_cnt - p0), 32'd0);
    step_btn = 1'b0; tick(20);
    step_btn = 1'b1; tick(20); step_btn = 1'b0; tick(20);
    chk("repress_after_reset", 32'(pulse_cnt - p0), 32'd1);

    btn_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) chan[$urandom_range(0, NCH-1)] = $urandom;
      if ($urandom_range(0, 2) == 0) ch_sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) freeze = ~freeze;
      if ($urandom_range(0, 15) == 0) page_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) run_mode = ~run_mode;
      if (btn_hold == 0) begin
        step_btn = ~step_btn;
        btn_hold = $urandom_range(1, 16);
      end else begin
        btn_hold--;
      end
      rst = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
